// File: rtl/ro_sensor_array.sv
// Multi-channel ring-oscillator frequency sensor: counts synchronised RO rising
// edges per channel over a programmable clk-cycle window, with alarm and overflow flags.
module ro_sensor_array #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 32,
  parameter int TIME_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ro_in,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [TIME_WIDTH-1:0]   meas_time,
  input  logic                    start,
  input  logic                    continuous,
  input  logic                    abort,
  input  logic [WIDTH-1:0]        thresh_lo,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       alarm
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_LATCH} state_t;

  state_t                r_state;
  logic [NUM_CH-1:0]     r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]     r_hist;
  logic [NUM_CH-1:0]     r_en_q;
  logic [NUM_CH-1:0]     r_ovf_run;
  logic [WIDTH-1:0]      r_cnt [NUM_CH];
  logic [TIME_WIDTH-1:0] r_timer;
  logic [TIME_WIDTH-1:0] r_win_len;

  logic [NUM_CH-1:0]     w_edge_en;
  logic                  w_win_last;

  assign w_edge_en  = r_sync[SYNC_STAGES-1] & ~r_hist & r_en_q;
  assign w_win_last = (r_timer == r_win_len - TIME_WIDTH'(1));
  assign busy       = (r_state != S_IDLE);

  // NOTE: the synchroniser and history flops run in every state, so the
  // history is already valid when a window opens and ARM never sees a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= ro_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // NOTE: every register here, including the counter array, is cleared by reset
  // because reset must leave all outputs and internal state at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_en_q    <= '0;
      r_ovf_run <= '0;
      r_timer   <= '0;
      r_win_len <= '0;
      done      <= 1'b0;
      count_out <= '0;
      overflow  <= '0;
      alarm     <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_win_len <= (meas_time == '0) ? TIME_WIDTH'(1) : meas_time;
              r_state   <= S_ARM;
            end
          end
          S_ARM: begin
            r_timer   <= '0;
            r_ovf_run <= '0;
            r_en_q    <= ch_en;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
            r_state   <= S_MEASURE;
          end
          S_MEASURE: begin
            r_timer <= r_timer + TIME_WIDTH'(1);
            // Saturate instead of wrapping; the overflow flag stays set for the window.
            for (int i = 0; i < NUM_CH; i++) begin
              if (w_edge_en[i]) begin
                if (&r_cnt[i]) r_ovf_run[i] <= 1'b1;
                else           r_cnt[i]     <= r_cnt[i] + WIDTH'(1);
              end
            end
            if (w_win_last) r_state <= S_LATCH;
          end
          S_LATCH: begin
            for (int i = 0; i < NUM_CH; i++) begin
              count_out[i*WIDTH +: WIDTH] <= r_cnt[i];
              alarm[i] <= r_en_q[i] && (r_cnt[i] < thresh_lo);
            end
            overflow <= r_ovf_run;
            done     <= 1'b1;
            r_state  <= continuous ? S_ARM : S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_sensor_array.sv
// Directed bench for ro_sensor_array: a scoreboard of expected window results
// is filled when a run is started and drained when done pulses.
module tb_ro_sensor_array;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int TW  = 32;

  logic            clk;
  logic            rst;
  logic [NCH-1:0]  ro_in;
  logic [NCH-1:0]  ch_en;
  logic [TW-1:0]   meas_time;
  logic            start;
  logic            continuous;
  logic            abort;
  logic [W-1:0]    thresh_lo;
  logic [3:0]      thresh_w4;
  logic            busy;
  logic            done;
  logic [NCH*W-1:0] count_out;
  logic [NCH-1:0]  overflow;
  logic [NCH-1:0]  alarm;
  logic            w4_busy;
  logic            w4_done;
  logic [NCH*4-1:0] w4_count;
  logic [NCH-1:0]  w4_ovf;
  logic [NCH-1:0]  w4_alm;

  int n_checks = 0;
  int n_fail   = 0;
  int ro_half [NCH];   // RO half period in ns; 0 holds the line low

  typedef struct packed {
    logic [31:0]          lat;
    logic                 busy;
    logic [NCH-1:0][31:0] lo;
    logic [NCH-1:0][31:0] hi;
    logic [NCH-1:0]       ovf;
    logic [NCH-1:0]       alm;
  } exp_t;

  exp_t sb [$];

  ro_sensor_array #(.NUM_CH(NCH), .WIDTH(W), .TIME_WIDTH(TW), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .ch_en(ch_en), .meas_time(meas_time),
    .start(start), .continuous(continuous), .abort(abort), .thresh_lo(thresh_lo),
    .busy(busy), .done(done), .count_out(count_out), .overflow(overflow), .alarm(alarm)
  );

  // Narrow-counter copy sharing all stimulus, used for the saturation cases.
  ro_sensor_array #(.NUM_CH(NCH), .WIDTH(4), .TIME_WIDTH(TW), .SYNC_STAGES(2)) u_dut_w4 (
    .clk(clk), .rst(rst), .ro_in(ro_in), .ch_en(ch_en), .meas_time(meas_time),
    .start(start), .continuous(continuous), .abort(abort), .thresh_lo(thresh_w4),
    .busy(w4_busy), .done(w4_done), .count_out(w4_count), .overflow(w4_ovf), .alarm(w4_alm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RO edges land 3 ns after a negedge, well clear of the sampling posedge.
  for (genvar g = 0; g < NCH; g++) begin : g_ro
    logic r_ro;
    initial begin
      r_ro = 1'b0;
      #3;
      forever begin
        if (ro_half[g] == 0) begin
          r_ro = 1'b0;
          #10;
        end else begin
          #(ro_half[g]);
          r_ro = ~r_ro;
        end
      end
    end
    assign ro_in[g] = r_ro;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input longint obs, input longint lo, input longint hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Edge count of a running RO in a win-cycle window is floor or ceil of win/period;
  // one extra count of slack either side covers synchroniser phase.
  function automatic exp_t make_exp(input int lat, input int win, input logic [NCH-1:0] en,
                                    input int thr, input logic b);
    exp_t e;
    e.lat  = lat;
    e.busy = b;
    e.ovf  = '0;
    e.alm  = '0;
    for (int c = 0; c < NCH; c++) begin
      int nom;
      nom = (en[c] && ro_half[c] != 0) ? win / (ro_half[c] / 5) : 0;
      e.lo[c]  = (en[c] && ro_half[c] != 0 && nom > 0) ? nom - 1 : nom;
      e.hi[c]  = (en[c] && ro_half[c] != 0) ? nom + 1 : nom;
      e.alm[c] = en[c] && (nom < thr);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      step();
      n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic check_next(input string tag);
    exp_t e;
    int   n;
    bit   got;
    e = sb.pop_front();
    wait_done(int'(e.lat) + 10, n, got);
    check_eq({tag, ".done_seen"}, 128'(got), 128'(1));
    check_eq({tag, ".latency"}, 128'(n), 128'(e.lat));
    check_eq({tag, ".busy"}, 128'(busy), 128'(e.busy));
    for (int c = 0; c < NCH; c++)
      check_rng($sformatf("%s.cnt%0d", tag, c), longint'(count_out[c*W +: W]),
                longint'(e.lo[c]), longint'(e.hi[c]));
    check_eq({tag, ".overflow"}, 128'(overflow), 128'(e.ovf));
    check_eq({tag, ".alarm"}, 128'(alarm), 128'(e.alm));
  endtask

  initial begin
    logic [NCH*W-1:0] snap;
    int               n_done;

    rst        = 1'b1;
    ch_en      = '0;
    meas_time  = '0;
    start      = 1'b0;
    continuous = 1'b0;
    abort      = 1'b0;
    thresh_lo  = '0;
    thresh_w4  = '0;
    ro_half    = '{50, 20, 100, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset.busy", 128'(busy), 128'(0));
    check_eq("reset.done", 128'(done), 128'(0));
    check_eq("reset.count_out", 128'(count_out), 128'(0));
    check_eq("reset.overflow", 128'(overflow), 128'(0));
    check_eq("reset.alarm", 128'(alarm), 128'(0));
    check_eq("reset.w4_busy", 128'(w4_busy), 128'(0));

    // Periods 10/4/20 clk, ch3 static, 100-cycle window.
    ch_en     = 4'hF;
    meas_time = 100;
    sb.push_back(make_exp(103, 100, 4'hF, 0, 1'b0));
    start = 1'b1;
    check_next("t1");
    // Narrow copy: ch1 sees ~25 edges, must stop at 15 and flag overflow.
    check_eq("t2.w4_done", 128'(w4_done), 128'(1));
    check_eq("t2.w4_cnt1_sat", 128'(w4_count[7:4]), 128'(15));
    check_eq("t2.w4_ovf", 128'(w4_ovf), 128'(4'b0010));
    check_eq("t2.w4_alm", 128'(w4_alm), 128'(0));

    // Short window: ch1 ~5 edges, no saturation.
    meas_time = 20;
    sb.push_back(make_exp(23, 20, 4'hF, 0, 1'b0));
    start = 1'b1;
    check_next("t2b");
    check_rng("t2b.w4_cnt1", longint'(w4_count[7:4]), 4, 6);
    check_eq("t2b.w4_ovf", 128'(w4_ovf), 128'(0));

    // Low-count alarm with two channels disabled.
    ro_half   = '{50, 100, 20, 20};
    ch_en     = 4'b0011;
    thresh_lo = 8;
    meas_time = 100;
    sb.push_back(make_exp(103, 100, 4'b0011, 8, 1'b0));
    start = 1'b1;
    check_next("t5");
    snap = count_out;

    // Abort in MEASURE cycle 20: no done, latched results untouched.
    ch_en     = 4'hF;
    thresh_lo = 0;
    start     = 1'b1;
    repeat (21) step();
    check_eq("t4.busy_before", 128'(busy), 128'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("t4.busy_after", 128'(busy), 128'(0));
    n_done = 0;
    repeat (120) begin
      step();
      if (done) n_done++;
    end
    check_eq("t4.no_done", 128'(n_done), 128'(0));
    check_eq("t4.count_hold", 128'(count_out), 128'(snap));
    check_eq("t4.count_ch23", 128'(count_out[4*W-1:2*W]), 128'(0));
    check_eq("t4.alarm_hold", 128'(alarm), 128'(4'b0010));
    check_eq("t4.ovf_hold", 128'(overflow), 128'(0));

    // Continuous mode: done period N+2, then one final window after dropping it.
    ro_half    = '{50, 20, 100, 0};
    meas_time  = 50;
    continuous = 1'b1;
    sb.push_back(make_exp(53, 50, 4'hF, 0, 1'b1));
    sb.push_back(make_exp(52, 50, 4'hF, 0, 1'b1));
    sb.push_back(make_exp(52, 50, 4'hF, 0, 1'b1));
    start = 1'b1;
    check_next("t3.w1");
    check_next("t3.w2");
    check_next("t3.w3");
    repeat (20) step();
    continuous = 1'b0;
    sb.push_back(make_exp(32, 50, 4'hF, 0, 1'b0));
    check_next("t3.last");
    n_done = 0;
    repeat (60) begin
      step();
      if (done) n_done++;
    end
    check_eq("t3.no_more_done", 128'(n_done), 128'(0));
    check_eq("t3.idle", 128'(busy), 128'(0));

    // Reset mid-MEASURE clears everything, then a zero-length request runs one cycle.
    meas_time = 100;
    start     = 1'b1;
    repeat (30) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6.busy", 128'(busy), 128'(0));
    check_eq("t6.done", 128'(done), 128'(0));
    check_eq("t6.count_out", 128'(count_out), 128'(0));
    check_eq("t6.overflow", 128'(overflow), 128'(0));
    check_eq("t6.alarm", 128'(alarm), 128'(0));
    check_eq("t6.w4_count", 128'(w4_count), 128'(0));
    meas_time = 0;
    sb.push_back(make_exp(4, 1, 4'hF, 0, 1'b0));
    start = 1'b1;
    check_next("t6.win1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
